// File: rtl/mat_stream_tx.sv
// Matrix-to-element streamer: captures one N x N matrix from a flat bus and
// emits its elements one per accepted beat with row/column tags and a last flag.
module mat_stream_tx #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter bit COL_MAJOR = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*N*WIDTH-1:0]   in_flat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_row,
    output logic [$clog2(N)-1:0]   out_col,
    output logic                   out_last
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    // Handshake: a transfer happens on any rising edge where valid && ready;
    // out_* hold steady while out_valid && !out_ready.
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic [IW-1:0] row_q, row_d, col_q, col_d;
    // Packed so that buf_q[r][c] lands on in_flat[(r*N+c)*WIDTH +: WIDTH]
    logic [N-1:0][N-1:0][WIDTH-1:0] buf_q;
    logic at_last, accept, capture;

    assign at_last   = (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign out_valid = (state_q == STREAM);
    assign accept    = out_valid && out_ready;
    assign out_last  = out_valid && at_last;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_data  = buf_q[row_q][col_q];

    // Ready again during the final beat so the next matrix follows with no bubble
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (state_q == IDLE) begin
                in_ready = 1'b1;
            end else if (accept && at_last) begin
                in_ready = 1'b1;
            end
        end
    end

    assign capture = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        if (capture) begin
            state_d = STREAM;
            row_d   = '0;
            col_d   = '0;
        end else if (accept) begin
            if (at_last) begin
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
            end else if (COL_MAJOR) begin
                if (row_q == LAST_IDX) begin
                    row_d = '0;
                    col_d = col_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                if (col_q == LAST_IDX) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            if (capture) begin
                buf_q <= in_flat;
            end
        end
    end
endmodule

// File: tb/tb_mat_stream_tx.sv
// Bench for mat_stream_tx: row-major and column-major N=4 instances share inputs,
// plus an N=2, WIDTH=1 instance for the small boundary case.
module tb_mat_stream_tx;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int FW = N * N * W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid, out_ready;
    logic [FW-1:0] in_flat;
    logic          rm_in_ready, rm_out_valid, rm_out_last;
    logic [W-1:0]  rm_out_data;
    logic [1:0]    rm_out_row, rm_out_col;
    logic          cm_in_ready, cm_out_valid, cm_out_last;
    logic [W-1:0]  cm_out_data;
    logic [1:0]    cm_out_row, cm_out_col;

    logic       n2_in_valid, n2_in_ready, n2_out_valid, n2_out_ready, n2_out_last;
    logic [3:0] n2_in_flat;
    logic [0:0] n2_out_data, n2_out_row, n2_out_col;

    mat_stream_tx #(.N(N), .WIDTH(W), .COL_MAJOR(1'b0)) dut_rm (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rm_in_ready), .in_flat(in_flat),
        .out_valid(rm_out_valid), .out_ready(out_ready), .out_data(rm_out_data),
        .out_row(rm_out_row), .out_col(rm_out_col), .out_last(rm_out_last)
    );

    mat_stream_tx #(.N(N), .WIDTH(W), .COL_MAJOR(1'b1)) dut_cm (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(cm_in_ready), .in_flat(in_flat),
        .out_valid(cm_out_valid), .out_ready(out_ready), .out_data(cm_out_data),
        .out_row(cm_out_row), .out_col(cm_out_col), .out_last(cm_out_last)
    );

    mat_stream_tx #(.N(2), .WIDTH(1), .COL_MAJOR(1'b0)) dut_n2 (
        .clk(clk), .rst(rst), .in_valid(n2_in_valid), .in_ready(n2_in_ready), .in_flat(n2_in_flat),
        .out_valid(n2_out_valid), .out_ready(n2_out_ready), .out_data(n2_out_data),
        .out_row(n2_out_row), .out_col(n2_out_col), .out_last(n2_out_last)
    );

    // Beat record: {last, row, col, data}
    typedef logic [12:0] beat_t;
    beat_t rm_q[$];
    beat_t cm_q[$];
    beat_t prev_beat[2];
    bit    prev_stall[2];

    logic [W-1:0] drv_mat[N][N];
    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         rdy;
        logic [7:0] rm_d;
        logic [1:0] rm_r;
        logic [1:0] rm_c;
        logic [7:0] cm_d;
        bit         last;
    } vec_t;
    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_mat(input int base);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                drv_mat[r][c] = W'(base + 10 * r + c);
    endtask

    // Reference: the whole emission order of a captured matrix, built up front
    task automatic push_model(input bit sel);
        for (int k = 0; k < N * N; k++) begin
            int r, c;
            beat_t b;
            if (sel) begin
                c = k / N;
                r = k % N;
            end else begin
                r = k / N;
                c = k % N;
            end
            b = {(k == N * N - 1), 2'(r), 2'(c), drv_mat[r][c]};
            if (sel) cm_q.push_back(b);
            else rm_q.push_back(b);
        end
    endtask

    task automatic check_inst(input bit sel);
        logic v, ir, l;
        logic [W-1:0] d;
        logic [1:0] r, c;
        beat_t cur, front;
        bit has;
        string tag;
        if (sel) begin
            v = cm_out_valid; ir = cm_in_ready; l = cm_out_last; d = cm_out_data;
            r = cm_out_row; c = cm_out_col; tag = "cm";
            has = (cm_q.size() > 0);
            front = has ? cm_q[0] : '0;
        end else begin
            v = rm_out_valid; ir = rm_in_ready; l = rm_out_last; d = rm_out_data;
            r = rm_out_row; c = rm_out_col; tag = "rm";
            has = (rm_q.size() > 0);
            front = has ? rm_q[0] : '0;
        end
        cur = {l, r, c, d};
        check({tag, "_valid"}, 32'(v), 32'(has));
        check({tag, "_in_ready"}, 32'(ir), 32'(!has || (front[12] && out_ready)));
        if (prev_stall[sel]) check({tag, "_hold"}, 32'({v, cur}), 32'({1'b1, prev_beat[sel]}));
        if (v && has) begin
            check({tag, "_beat"}, 32'(cur), 32'(front));
            if (out_ready) begin
                if (sel) void'(cm_q.pop_front());
                else void'(rm_q.pop_front());
            end
        end
        prev_stall[sel] = v && !out_ready;
        prev_beat[sel]  = cur;
        if (in_valid && ir) push_model(sel);
    endtask

    // Called just after a falling edge; returns at the next falling edge
    task automatic tick();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                in_flat[(r * N + c) * W +: W] = drv_mat[r][c];
        #1;
        check_inst(1'b0);
        check_inst(1'b1);
        @(negedge clk);
    endtask

    task automatic drain();
        int budget = 200;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((rm_q.size() > 0 || cm_q.size() > 0) && budget > 0) begin
            tick();
            budget--;
        end
        check("drain_done", 32'(rm_q.size() + cm_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_flat = '0;
        n2_in_valid = 1'b0; n2_out_ready = 1'b0; n2_in_flat = '0;
        prev_stall[0] = 1'b0; prev_stall[1] = 1'b0;
        set_mat(0);
        for (int i = 0; i < 16; i++) begin
            tbl[i].rdy  = 1'b1;
            tbl[i].rm_d = 8'(10 * (i / 4) + (i % 4));
            tbl[i].rm_r = 2'(i / 4);
            tbl[i].rm_c = 2'(i % 4);
            tbl[i].cm_d = 8'(10 * (i % 4) + (i / 4));
            tbl[i].last = (i == 15);
        end

        // Reset state
        #2;
        check("rst_rm_out", 32'({rm_out_valid, rm_out_data, rm_out_row, rm_out_col, rm_out_last}), 32'd0);
        check("rst_rm_in_ready", 32'(rm_in_ready), 32'd0);
        check("rst_n2_in_ready", 32'(n2_in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'({rm_in_ready, cm_in_ready, n2_in_ready}), 32'h7);
        check("post_rst_valid", 32'({rm_out_valid, cm_out_valid, n2_out_valid}), 32'd0);

        // Basic row-major / column-major, table-driven
        set_mat(0);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            out_ready = tbl[i].rdy;
            #1;
            check("tbl_rm", 32'({rm_out_valid, rm_out_data, rm_out_row, rm_out_col, rm_out_last}),
                  32'({1'b1, tbl[i].rm_d, tbl[i].rm_r, tbl[i].rm_c, tbl[i].last}));
            check("tbl_cm", 32'({cm_out_valid, cm_out_data, cm_out_last}),
                  32'({1'b1, tbl[i].cm_d, tbl[i].last}));
            tick();
        end
        #1;
        check("tbl_idle", 32'({rm_in_ready, rm_out_valid, cm_in_ready, cm_out_valid}), 32'b1010);

        // Randomized backpressure, in_flat churn and random new requests
        for (int i = 0; i < 400; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) == 0);
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    drv_mat[r][c] = W'($urandom);
            tick();
        end
        drain();

        // Back-to-back: B follows A with no idle cycle
        set_mat(0);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        set_mat(100);
        for (int i = 0; i < 16; i++) tick();
        in_valid = 1'b0;
        #1;
        check("b2b_first", 32'({rm_out_valid, rm_out_data, rm_out_row, rm_out_col}),
              32'({1'b1, 8'd100, 2'd0, 2'd0}));
        drain();

        // Reset mid-stream after the 5th accepted beat
        set_mat(0);
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        check("midrst_rm_out", 32'({rm_out_valid, rm_out_data, rm_out_row, rm_out_col, rm_out_last}), 32'd0);
        check("midrst_cm_out", 32'({cm_out_valid, cm_out_data, cm_out_row, cm_out_col, cm_out_last}), 32'd0);
        check("midrst_in_ready", 32'({rm_in_ready, cm_in_ready}), 32'd0);
        rm_q.delete(); cm_q.delete();
        prev_stall[0] = 1'b0; prev_stall[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after_rst_ready", 32'({rm_in_ready, cm_in_ready, rm_out_valid, cm_out_valid}), 32'b1100);
        set_mat(100);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();

        // N=2, WIDTH=1 all-ones boundary
        n2_in_flat = 4'hf; n2_in_valid = 1'b1; n2_out_ready = 1'b1;
        @(negedge clk);
        n2_in_valid = 1'b0;
        n2_in_flat  = 4'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("n2_beat", 32'({n2_out_valid, n2_out_data, n2_out_row, n2_out_col, n2_out_last, n2_in_ready}),
                  32'({1'b1, 1'b1, 1'(i / 2), 1'(i % 2), (i == 3), (i == 3)}));
            @(negedge clk);
        end
        #1;
        check("n2_idle", 32'({n2_out_valid, n2_in_ready}), 32'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/mat_stream_tx.md
# mat_stream_tx

Matrix-to-element streamer: accepts one N×N matrix of WIDTH-bit elements as a flat packed vector over a valid/ready handshake. It then emits the elements one per accepted beat, with row/column tags and a last flag. It is the serial transmit end for flat matrix buses. It sits between matrix-producing compute blocks and element-serial consumers such as the element-stream matrix packer and the DMA write path.

## Interface
- N, 4, matrix dimension (rows = cols = N), N ≥ 2
- WIDTH, 8, element width in bits, ≥ 1
- COL_MAJOR, 0, 0 = row-major emission order, 1 = column-major emission order
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_flat holds a matrix
- in_ready  out  1  block can capture a matrix this cycle
- in_flat  in  N*N*WIDTH  packed matrix; element (r,c) = in_flat[(r*N+c)*WIDTH +: WIDTH], so (0,0) is at the LSBs
- out_valid  out  1  out_* fields hold an element
- out_ready  in  1  consumer accepts the element
- out_data  out  WIDTH  element value
- out_row  out  $clog2(N)  row index of out_data
- out_col  out  $clog2(N)  column index of out_data
- out_last  out  1  high on the final element of the matrix

## Operation
- FSM has two states: IDLE and STREAM.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - When in_valid && in_ready, capture in_flat into the matrix buffer, set the index to (0,0) and go to STREAM.
- STREAM:
  - out_valid = 1.
  - out_data is the buffer element at (out_row, out_col).
  - out_last = 1 exactly when the element is the final one: (N-1,N-1) in either order.
- Beat accepted = out_valid && out_ready. On acceptance the index advances:
  - Row-major: col increments; on col wrap (N-1→0), row increments.
  - Column-major: row increments; on row wrap, col increments.
- Accepting the last beat returns the FSM to IDLE and wraps the index to (0,0).
- Back-to-back matrices:
  - in_ready is also 1 in STREAM during the cycle the last beat is accepted (combinational path from out_ready).
  - If in_valid is also high in that cycle, capture the new matrix and stay in STREAM at index (0,0). There is no bubble.
- in_ready is 0 in STREAM except in the last-beat case above. in_flat changes while in_ready = 0 are ignored.
- AXI-style stability: once out_valid is high, out_data, out_row, out_col and out_last hold until accepted. out_valid never drops without acceptance.
- The buffer is only written on input capture. Emitted data must equal the captured data regardless of later in_flat changes.
- Reset asserted at any time, including mid-stream:
  - Go to IDLE, index (0,0), buffer cleared to 0.
  - out_valid, out_data, out_row, out_col and out_last are 0; in_ready is 0 while rst is high.
  - The partial matrix is discarded and there is no out_last for it.

## Timing
- Reset values: out_valid 0, out_data 0, out_row 0, out_col 0, out_last 0, in_ready 0 during reset. in_ready = 1 in the first cycle after rst deasserts.
- Latency: a matrix captured at edge k gives out_valid = 1 with element (0,0) after edge k, i.e. in cycle k+1.
- Throughput: one element per cycle with out_ready held high. A matrix takes N*N cycles. Back-to-back matrices stream continuously.
- out_valid, out_data, out_row, out_col and out_last are registered or decoded from registered state only, with no combinational path from in_* to out_*.
- in_ready depends combinationally only on state, index, out_ready and rst.

## Test plan
- Basic row-major (N=4, WIDTH=8, COL_MAJOR=0): load A[r][c] = 10r+c, hold out_ready = 1 -> 16 beats in consecutive cycles:
  - data 0,1,2,3,10,…,33 with matching row/col tags;
  - out_last only on 33;
  - then in_ready = 1 and out_valid = 0.
- Column-major (COL_MAJOR=1), same matrix -> data 0,10,20,30,1,11,…,33, out_last on 33.
- Backpressure: toggle out_ready pseudo-randomly and change in_flat during STREAM -> same 16-value sequence, fields stable while stalled, no beat duplicated or dropped, in_ready = 0 until the last beat.
- Back-to-back: present matrix B[r][c] = 100+10r+c with in_valid held -> beat 33 is followed in the very next cycle by 100 at (0,0), with no idle cycle.
- Reset mid-stream: assert rst after the 5th accepted beat -> outputs 0 immediately (asynchronous). After release: in_ready = 1 and out_valid = 0. A new load streams from (0,0) correctly.
- Boundary: N=2, WIDTH=1, all-ones matrix -> 4 beats of 1, tags (0,0),(0,1),(1,0),(1,1), out_last on the 4th.
